// File: rtl/fp_tag_pipeline.sv
// fp_tag_pipeline: latency-matching valid/tag delay line with selectable depth, flush and occupancy
//   clk        rising-edge clock
//   aclr_n     asynchronous active-low reset
//   clk_en     advance enable, 0 freezes all state
//   flush      synchronous discard of all in-flight entries (acts regardless of clk_en)
//   in_valid   entry present this cycle
//   in_tag     sideband tag of the entry
//   lat_sel    0 selects STAGES_MAX, 1 selects STAGES_ALT (applied only while empty)
//   out_valid  entry leaving this cycle
//   out_nop    ~out_valid
//   out_tag    tag of the leaving entry
//   occupancy  entries in flight, including the output stage
//   empty      occupancy == 0
//   lat_active latency selection currently applied
module fp_tag_pipeline #(
    parameter int STAGES_MAX = 7,
    parameter int STAGES_ALT = 5,
    parameter int TAG_W = 8,
    localparam int CNT_W = $clog2(STAGES_MAX + 1)
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             lat_sel,
    output logic             out_valid,
    output logic             out_nop,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] occupancy,
    output logic             empty,
    output logic             lat_active
);
    // stages at or beyond the short latency are forced invalid in short mode
    localparam logic [STAGES_MAX-1:0] ALT_MASK = {{(STAGES_MAX - STAGES_ALT){1'b0}}, {STAGES_ALT{1'b1}}};
    logic [STAGES_MAX-1:0] v;
    logic [TAG_W-1:0]      t [STAGES_MAX];
    logic [CNT_W-1:0]      occ;
    always_comb begin
        out_valid = lat_active ? v[STAGES_ALT-1] : v[STAGES_MAX-1];
        out_tag   = lat_active ? t[STAGES_ALT-1] : t[STAGES_MAX-1];
        out_nop   = ~out_valid;
        occupancy = occ;
        empty     = occ == '0;
    end
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            v          <= '0;
            occ        <= '0;
            lat_active <= 1'b0;
            for (int i = 0; i < STAGES_MAX; i++) t[i] <= '0;
        end else begin
            // switching only while drained keeps every in-flight entry on one latency
            if (clk_en && occ == '0) lat_active <= lat_sel;
            if (flush) begin
                v   <= '0;
                occ <= '0;
            end else if (clk_en) begin
                v    <= {v[STAGES_MAX-2:0], in_valid} & (lat_active ? ALT_MASK : '1);
                t[0] <= in_tag;
                for (int i = 1; i < STAGES_MAX; i++) t[i] <= t[i-1];
                occ  <= occ + CNT_W'(in_valid) - CNT_W'(out_valid);
            end
        end
    end
endmodule

// File: tb/tb_fp_tag_pipeline.sv
// tb_fp_tag_pipeline: scoreboard bench for fp_tag_pipeline
module tb_fp_tag_pipeline;
    logic       clk = 1'b0;
    logic       aclr_n, clk_en, flush, in_valid, lat_sel;
    logic [7:0] in_tag;
    logic       out_valid, out_nop, empty, lat_active;
    logic [7:0] out_tag;
    logic [2:0] occupancy;
    typedef struct {
        logic [7:0] tag;
        int         due;
    } exp_t;
    exp_t q[$];
    int   due_q[$];
    int   checks = 0, failures = 0;
    int   en_cnt = 0, m_occ = 0, seen;
    logic m_lat = 1'b0, fresh = 1'b1, pv = 1'b0;
    logic [7:0] pt = '0;
    exp_t e;

    fp_tag_pipeline dut (
        .clk(clk), .aclr_n(aclr_n), .clk_en(clk_en), .flush(flush),
        .in_valid(in_valid), .in_tag(in_tag), .lat_sel(lat_sel),
        .out_valid(out_valid), .out_nop(out_nop), .out_tag(out_tag),
        .occupancy(occupancy), .empty(empty), .lat_active(lat_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, x);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] tg, input logic en, input logic fl, input logic sel);
        in_valid = v;
        in_tag   = tg;
        clk_en   = en;
        flush    = fl;
        lat_sel  = sel;
        @(posedge clk);
        #1;
        if (en && m_occ == 0) m_lat = sel;
        if (fl) begin
            due_q.delete();
            q.delete();
        end else if (en) begin
            en_cnt++;
            while (due_q.size() > 0 && due_q[0] < en_cnt) void'(due_q.pop_front());
            if (v) begin
                due_q.push_back(en_cnt + (m_lat ? 5 : 7) - 1);
                q.push_back('{tg, en_cnt + (m_lat ? 5 : 7) - 1});
            end
        end
        m_occ = due_q.size();
        fresh = en | fl;
    endtask

    task automatic idle(input int n, input logic sel);
        repeat (n) step(1'b0, 8'h00, 1'b1, 1'b0, sel);
    endtask

    always @(negedge clk) begin
        if (aclr_n) begin
            chk("occupancy", occupancy, m_occ);
            chk("empty", empty, m_occ == 0);
            chk("out_nop", out_nop, !out_valid);
            chk("lat_active", lat_active, m_lat);
            if (!fresh) begin
                chk("stall_valid", out_valid, pv);
                chk("stall_tag", out_tag, pt);
            end else if (out_valid) begin
                if (q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("out_tag", out_tag, e.tag);
                    chk("out_edge", en_cnt, e.due);
                end
            end
            pv = out_valid;
            pt = out_tag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        aclr_n = 1'b0; clk_en = 1'b0; flush = 1'b0; in_valid = 1'b0; lat_sel = 1'b0; in_tag = '0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_nop", out_nop, 1);
        chk("rst_tag", out_tag, 0);
        chk("rst_empty", empty, 1);
        repeat (2) @(posedge clk);
        #3 aclr_n = 1'b1;
        // single entry at L=7
        step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b0);
        chk("t1_early", out_valid, 0);
        idle(1, 1'b0);
        chk("t1_valid", out_valid, 1);
        chk("t1_tag", out_tag, 8'h11);
        chk("t1_occ", occupancy, 1);
        idle(1, 1'b0);
        chk("t1_occ0", occupancy, 0);
        chk("t1_empty", empty, 1);
        // back-to-back at L=5
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
            if (i == 4) chk("t2_peak", occupancy, 5);
        end
        idle(6, 1'b1);
        // stall mid-flight at L=7
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("t3_early", out_valid, 0);
        idle(1, 1'b0);
        chk("t3_valid", out_valid, 1);
        chk("t3_tag", out_tag, 8'h33);
        idle(1, 1'b0);
        // latency switch pending under load
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
        idle(7, 1'b1);
        chk("t4_held", lat_active, 0);
        chk("t4_drained", empty, 1);
        step(1'b1, 8'h4f, 1'b1, 1'b0, 1'b1);
        chk("t4_switched", lat_active, 1);
        idle(3, 1'b1);
        chk("t4_early", out_valid, 0);
        idle(1, 1'b1);
        chk("t4_valid", out_valid, 1);
        chk("t4_tag", out_tag, 8'h4f);
        idle(1, 1'b1);
        // flush at occupancy 4 with simultaneous entry
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b1);
        chk("t5_occ4", occupancy, 4);
        step(1'b1, 8'h5f, 1'b1, 1'b1, 1'b1);
        chk("t5_occ0", occupancy, 0);
        chk("t5_empty", empty, 1);
        seen = 0;
        repeat (7) begin
            idle(1, 1'b1);
            seen += int'(out_valid);
        end
        chk("t5_quiet", seen, 0);
        // asynchronous reset with 5 in flight
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b1);
        chk("t6_occ5", occupancy, 5);
        chk("t6_pre_valid", out_valid, 1);
        #2 aclr_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_nop", out_nop, 1);
        chk("t6_tag", out_tag, 0);
        chk("t6_occ", occupancy, 0);
        chk("t6_empty", empty, 1);
        chk("t6_lat", lat_active, 0);
        q.delete();
        due_q.delete();
        m_occ = 0;
        m_lat = 1'b0;
        fresh = 1'b1;
        @(posedge clk);
        #3 aclr_n = 1'b1;
        step(1'b1, 8'haa, 1'b1, 1'b0, 1'b0);
        idle(5, 1'b0);
        chk("t6_early", out_valid, 0);
        idle(1, 1'b0);
        chk("t6_new_valid", out_valid, 1);
        chk("t6_new_tag", out_tag, 8'haa);
        idle(2, 1'b0);
        chk("drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
